// File: rtl/lfsr_pkg.sv
// Shared definitions for the PRBS generator/checker pair: checker states and
// the stock maximal-length feedback masks for 8- and 16-bit registers.
package lfsr_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } chk_state_e;

    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;

endpackage

// File: rtl/lfsr_chk.sv
// PRBS checker: self-synchronising predictor that hunts for WIDTH clean matches,
// then flags and counts mismatches until LOSS_N in a row force a re-hunt.
module lfsr_chk
    import lfsr_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] TAPS   = WIDTH'(TAPS_8),
    parameter int               LOSS_N = 3,
    parameter int               CNT_W  = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             data_i,
    input  logic             clr_err_i,
    output chk_state_e       state_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam int MW = $clog2(WIDTH + 1);
    localparam int LW = $clog2(LOSS_N + 1);

    logic [WIDTH-1:0] chk_q, chk_d;
    logic [MW-1:0]    match_q, match_d;
    logic [LW-1:0]    miss_q, miss_d;
    chk_state_e       state_q, state_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pred, mis;

    always_comb begin
        pred    = ^(chk_q & TAPS);
        mis     = pred ^ data_i;
        chk_d   = chk_q;
        match_d = match_q;
        miss_d  = miss_q;
        state_d = state_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        if (en_i) begin
            chk_d = {chk_q[WIDTH-2:0], data_i};
            case (state_q)
                HUNT: begin
                    // An all-zero history predicts nothing, so it never counts as a match.
                    if (!mis && chk_q != '0) begin
                        if (match_q == MW'(WIDTH - 1)) begin
                            match_d = '0;
                            state_d = LOCK;
                        end else begin
                            match_d = match_q + 1'b1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCK: begin
                    if (mis) begin
                        err_d = 1'b1;
                        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                        if (miss_q == LW'(LOSS_N - 1)) begin
                            miss_d  = '0;
                            state_d = HUNT;
                        end else begin
                            miss_d = miss_q + 1'b1;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        if (clr_err_i) cnt_d = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chk_q   <= '0;
            match_q <= '0;
            miss_q  <= '0;
            state_q <= HUNT;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            chk_q   <= chk_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            state_q <= state_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o   = state_q;
    assign err_o     = err_q;
    assign err_cnt_o = cnt_q;

endmodule

// File: rtl/lfsr_prbs.sv
// Fibonacci LFSR PRBS generator with serial seed load, lock-up recovery and
// wrap detection, plus an independent PRBS checker.
module lfsr_prbs
    import lfsr_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] TAPS   = WIDTH'(TAPS_8),
    parameter logic [WIDTH-1:0] SEED   = WIDTH'(1),
    parameter int               LOSS_N = 3,
    parameter int               CNT_W  = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             LOAD,
    input  logic             SEED_IN,
    input  logic             CHK_EN,
    input  logic             CHECK_IN,
    input  logic             CLR_ERR,
    output logic [WIDTH-1:0] STATE,
    output logic             BIT,
    output logic             PERIOD,
    output logic             LOCKUP,
    output logic             LOCKED,
    output logic             ERR,
    output logic [CNT_W-1:0] ERR_COUNT
);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic             period_q, period_d;
    logic             lockup_q, lockup_d;
    chk_state_e       chk_state;

    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        period_d = 1'b0;
        lockup_d = 1'b0;
        if (LOAD) begin
            state_d = {state_q[WIDTH-2:0], SEED_IN};
            start_d = state_d;
        end else if (EN) begin
            // The all-zero state is a dead end for XOR feedback; jump back to SEED.
            if (state_q == '0) begin
                state_d  = SEED;
                lockup_d = 1'b1;
            end else begin
                state_d  = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
                period_d = (state_d == start_q);
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= SEED;
            start_q  <= SEED;
            period_q <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            period_q <= period_d;
            lockup_q <= lockup_d;
        end
    end

    lfsr_chk #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .LOSS_N(LOSS_N),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk_i    (CLK),
        .rst_i    (RESET),
        .en_i     (CHK_EN),
        .data_i   (CHECK_IN),
        .clr_err_i(CLR_ERR),
        .state_o  (chk_state),
        .err_o    (ERR),
        .err_cnt_o(ERR_COUNT)
    );

    assign STATE  = state_q;
    assign BIT    = state_q[WIDTH-1];
    assign PERIOD = period_q;
    assign LOCKUP = lockup_q;
    assign LOCKED = (chk_state == LOCK);

endmodule

// File: tb/tb_lfsr_prbs.sv
// Directed bench for lfsr_prbs: default 8-bit instance, a 2-bit error counter
// instance, and a 16-bit instance for the long wrap.
module tb_lfsr_prbs;

  logic clk, rst;

  // default 8-bit instance
  logic       a_en, a_load, a_seed, a_chk_en, a_flip, a_clr, a_check;
  logic [7:0] a_state, a_cnt;
  logic       a_bit, a_period, a_lockup, a_locked, a_err;

  // 8-bit instance with saturating 2-bit error counter
  logic       c_en, c_chk_en, c_flip, c_clr, c_check;
  logic [7:0] c_state;
  logic [1:0] c_cnt;
  logic       c_bit, c_period, c_lockup, c_locked, c_err;

  // 16-bit instance
  logic        w_en, w_zero;
  logic [15:0] w_state;
  logic [7:0]  w_cnt;
  logic        w_bit, w_period, w_lockup, w_locked, w_err;

  int n_cmp, n_bad;
  logic [7:0] exp_q[$];

  assign a_check = a_bit ^ a_flip;
  assign c_check = c_bit ^ c_flip;

  lfsr_prbs dut_a (
    .CLK(clk), .RESET(rst), .EN(a_en), .LOAD(a_load), .SEED_IN(a_seed),
    .CHK_EN(a_chk_en), .CHECK_IN(a_check), .CLR_ERR(a_clr),
    .STATE(a_state), .BIT(a_bit), .PERIOD(a_period), .LOCKUP(a_lockup),
    .LOCKED(a_locked), .ERR(a_err), .ERR_COUNT(a_cnt)
  );

  lfsr_prbs #(.LOSS_N(5), .CNT_W(2)) dut_c (
    .CLK(clk), .RESET(rst), .EN(c_en), .LOAD(w_zero), .SEED_IN(w_zero),
    .CHK_EN(c_chk_en), .CHECK_IN(c_check), .CLR_ERR(c_clr),
    .STATE(c_state), .BIT(c_bit), .PERIOD(c_period), .LOCKUP(c_lockup),
    .LOCKED(c_locked), .ERR(c_err), .ERR_COUNT(c_cnt)
  );

  lfsr_prbs #(.WIDTH(16), .TAPS(16'hB400), .SEED(16'h0001)) dut_w (
    .CLK(clk), .RESET(rst), .EN(w_en), .LOAD(w_zero), .SEED_IN(w_zero),
    .CHK_EN(w_zero), .CHECK_IN(w_zero), .CLR_ERR(w_zero),
    .STATE(w_state), .BIT(w_bit), .PERIOD(w_period), .LOCKUP(w_lockup),
    .LOCKED(w_locked), .ERR(w_err), .ERR_COUNT(w_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // scoreboard
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [7:0]  e;
    logic [31:0] err_v, lk_v;
    int          hits, first, second, errs, drops;
    int          c_exp[10];

    n_cmp = 0; n_bad = 0;
    a_en = 0; a_load = 0; a_seed = 0; a_chk_en = 0; a_flip = 0; a_clr = 0;
    c_en = 0; c_chk_en = 0; c_flip = 0; c_clr = 0;
    w_en = 0; w_zero = 0;
    rst = 1'b1;
    tick();
    tick();

    check_eq("rst_state", a_state, 8'h01);
    check_eq("rst_period", a_period, 0);
    check_eq("rst_lockup", a_lockup, 0);
    check_eq("rst_locked", a_locked, 0);
    check_eq("rst_err", a_err, 0);
    check_eq("rst_cnt", a_cnt, 0);
    check_eq("rst_w_state", w_state, 16'h0001);
    rst = 1'b0;

    // first steps from SEED, then hold
    exp_q.push_back(8'h02); exp_q.push_back(8'h04); exp_q.push_back(8'h08);
    exp_q.push_back(8'h11); exp_q.push_back(8'h23); exp_q.push_back(8'h47);
    exp_q.push_back(8'h8E); exp_q.push_back(8'h1C);
    a_en = 1;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      check_eq("seq_state", a_state, e);
      check_eq("seq_bit", a_bit, e[7]);
    end
    a_en = 0;
    repeat (3) tick();
    check_eq("hold", a_state, 8'h1C);

    // full period: wrap pulses at steps 255 and 510 only
    pulse_reset();
    a_en = 1;
    hits = 0; first = 0; second = 0;
    for (int s = 1; s <= 510; s++) begin
      tick();
      if (a_period) begin
        hits++;
        if (hits == 1) first = s;
        else if (hits == 2) second = s;
      end
      if (s == 255) check_eq("wrap255_state", a_state, 8'h01);
    end
    check_eq("period_hits", hits, 2);
    check_eq("period_first", first, 255);
    check_eq("period_second", second, 510);
    check_eq("period_end_state", a_state, 8'h01);

    // serial load of zeros, then lock-up recovery
    a_en = 0; a_load = 1; a_seed = 0; hits = 0;
    repeat (8) begin
      tick();
      if (a_period || a_lockup) hits++;
    end
    check_eq("load_zero_state", a_state, 8'h00);
    check_eq("load_no_pulse", hits, 0);
    a_load = 0; a_en = 1;
    tick();
    check_eq("recover_state", a_state, 8'h01);
    check_eq("recover_lockup", a_lockup, 1);
    check_eq("recover_period", a_period, 0);
    tick();
    check_eq("after_recover_state", a_state, 8'h02);
    check_eq("after_recover_lockup", a_lockup, 0);

    // LOAD wins over EN; load A5 then step
    a_load = 1; a_seed = 1;
    tick();
    check_eq("load_prio", a_state, 8'h05);
    e = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      a_seed = e[i];
      tick();
    end
    check_eq("load_a5", a_state, 8'hA5);
    a_load = 0;
    tick();
    check_eq("step_a5", a_state, 8'h4A);

    // checker lock on own stream
    a_en = 0;
    pulse_reset();
    a_en = 1; a_chk_en = 1; a_flip = 0;
    first = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (a_locked && first == 0) first = n;
    end
    check_eq("lock_latency", first, 16);
    errs = 0; drops = 0;
    repeat (1000) begin
      tick();
      if (a_err) errs++;
      if (!a_locked) drops++;
    end
    check_eq("clean_errs", errs, 0);
    check_eq("clean_drops", drops, 0);

    // single inverted bit: errors at offsets 0,4,5,6; drop after 6, relock at 16
    err_v = '0; lk_v = '0;
    for (int j = 0; j < 21; j++) begin
      a_flip = (j == 0);
      tick();
      err_v[j] = a_err;
      lk_v[j] = a_locked;
    end
    a_flip = 0;
    check_eq("flip_err_pattern", err_v, 32'h0000_0071);
    check_eq("flip_lock_pattern", lk_v, 32'h001F_003F);
    check_eq("flip_err_count", a_cnt, 4);

    // 2-bit counter: clear-vs-increment, then saturation under inversion
    pulse_reset();
    c_en = 1; c_chk_en = 1; c_flip = 0; c_clr = 0;
    repeat (16) tick();
    check_eq("c_locked", c_locked, 1);
    c_exp = '{1, 1, 1, 1, 0, 1, 2, 2, 3, 3};
    for (int j = 0; j < 10; j++) begin
      c_flip = (j == 0);
      c_clr = (j == 4);
      tick();
      check_eq("c_cnt_seq", c_cnt, c_exp[j]);
      if (j == 4) check_eq("c_err_with_clr", c_err, 1);
    end
    c_flip = 0; c_clr = 0;
    check_eq("c_still_locked", c_locked, 1);
    repeat (10) tick();
    c_clr = 1;
    tick();
    c_clr = 0;
    check_eq("c_clr", c_cnt, 0);
    err_v = '0; lk_v = '0; hits = 0;
    c_flip = 1;
    for (int s = 0; s < 15; s++) begin
      tick();
      err_v[s] = c_err;
      lk_v[s] = c_locked;
      if (s == 3) check_eq("c_sat_s3", c_cnt, 3);
    end
    check_eq("c_inv_err_pattern", err_v, 32'h0000_1F2F);
    check_eq("c_inv_lock_pattern", lk_v, 32'h0000_0FFF);
    check_eq("c_cnt_final", c_cnt, 3);

    // 16-bit wrap
    w_en = 1;
    hits = 0; first = 0;
    for (int s = 1; s <= 65540; s++) begin
      tick();
      if (s == 1) check_eq("w_step1", w_state, 16'h0002);
      if (w_period) begin
        hits++;
        if (hits == 1) first = s;
      end
      if (s == 65535) check_eq("w_wrap_state", w_state, 16'h0001);
    end
    check_eq("w_period_hits", hits, 1);
    check_eq("w_period_first", first, 65535);
    check_eq("w_pre_rst_state", w_state, 16'h0020);
    check_eq("a_pre_rst_locked", a_locked, 1);
    check_eq("c_pre_rst_cnt", c_cnt, 3);

    // asynchronous reset mid-run takes effect before the next edge
    rst = 1'b1;
    #1;
    check_eq("arst_a_state", a_state, 8'h01);
    check_eq("arst_a_locked", a_locked, 0);
    check_eq("arst_a_err", a_err, 0);
    check_eq("arst_a_period", a_period, 0);
    check_eq("arst_a_lockup", a_lockup, 0);
    check_eq("arst_a_cnt", a_cnt, 0);
    check_eq("arst_c_cnt", c_cnt, 0);
    check_eq("arst_w_state", w_state, 16'h0001);
    check_eq("arst_w_period", w_period, 0);
    rst = 1'b0;
    tick();

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
